// File: rtl/date_pkg.sv
// Shared date encoding: field widths, slice positions and the packed date word.
// The same slices are reused by the days-sum and display stages.
package date_pkg;

  localparam int unsigned DATE_W = 23;
  localparam int unsigned YEAR_W = 14;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned DAY_W  = 5;

  localparam int unsigned YEAR_HI = 22;
  localparam int unsigned YEAR_LO = 9;
  localparam int unsigned MON_HI  = 8;
  localparam int unsigned MON_LO  = 5;
  localparam int unsigned DAY_HI  = 4;
  localparam int unsigned DAY_LO  = 0;

  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  localparam logic [DATE_W-1:0] DEFAULT_RESET_DATE = {14'd2000, 4'd1, 5'd1};

  typedef struct packed {
    logic [YEAR_W-1:0] year;
    logic [MON_W-1:0]  mon;
    logic [DAY_W-1:0]  day;
  } date_t;

endpackage

// File: rtl/month_len.sv
// Gregorian month length and leap-year flag for a (year, month) pair.
// Months outside 1..12 report 31; callers validate the month separately.
module month_len
  import date_pkg::*;
(
  input  logic [YEAR_W-1:0] year,
  input  logic [MON_W-1:0]  month,
  output logic [DAY_W-1:0]  mlen,
  output logic              leap
);

  always_comb begin
    leap = (year[1:0] == 2'd0) &&
           (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
    mlen = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
      FEB:                     mlen = leap ? 5'd29 : 5'd28;
      default:                 mlen = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Running calendar date: day increment/decrement with full Gregorian rules,
// validated parallel load, and one-cycle year_wrap / load_err pulses.
module date_counter
  import date_pkg::*;
#(
  parameter int unsigned        YEAR_MIN   = 1,
  parameter int unsigned        YEAR_MAX   = 9999,
  parameter logic [DATE_W-1:0]  RESET_DATE = DEFAULT_RESET_DATE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              day_tick,
  input  logic              day_back,
  input  logic              load,
  input  logic [DATE_W-1:0] load_date,
  output logic [DATE_W-1:0] date_out,
  output logic              leap,
  output logic              year_wrap,
  output logic              load_err
);

  date_t             cur_q;
  date_t             cur_d;
  date_t             ld;
  logic              wrap_d;
  logic              err_d;
  logic              do_tick;
  logic              do_back;
  logic [MON_W-1:0]  lk_mon;
  logic [DAY_W-1:0]  cur_mlen;
  logic              cur_leap;
  logic [DAY_W-1:0]  ld_mlen;
  logic              ld_leap;
  logic              ld_ok;

  assign ld      = date_t'(load_date);
  assign do_tick = !load && day_tick && !day_back;
  assign do_back = !load && day_back && !day_tick;

  // Decrement needs the length of the previous month; reuse the same lookup.
  assign lk_mon = do_back ? (cur_q.mon - 4'd1) : cur_q.mon;

  month_len u_len_cur (
    .year  (cur_q.year),
    .month (lk_mon),
    .mlen  (cur_mlen),
    .leap  (cur_leap)
  );

  month_len u_len_load (
    .year  (ld.year),
    .month (ld.mon),
    .mlen  (ld_mlen),
    .leap  (ld_leap)
  );

  assign ld_ok = (ld.year >= YEAR_W'(YEAR_MIN)) && (ld.year <= YEAR_W'(YEAR_MAX)) &&
                 (ld.mon != '0) && (ld.mon <= DEC) &&
                 (ld.day != '0) && (ld.day <= ld_mlen);

  always_comb begin
    cur_d  = cur_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (ld_ok) cur_d = ld;
      else       err_d = 1'b1;
    end else if (do_tick) begin
      if (cur_q.day < cur_mlen) begin
        cur_d.day = cur_q.day + 5'd1;
      end else begin
        cur_d.day = 5'd1;
        if (cur_q.mon < DEC) begin
          cur_d.mon = cur_q.mon + 4'd1;
        end else begin
          cur_d.mon = 4'd1;
          if (cur_q.year == YEAR_W'(YEAR_MAX)) begin
            cur_d.year = YEAR_W'(YEAR_MIN);
            wrap_d     = 1'b1;
          end else begin
            cur_d.year = cur_q.year + 14'd1;
          end
        end
      end
    end else if (do_back) begin
      if (cur_q.day > 5'd1) begin
        cur_d.day = cur_q.day - 5'd1;
      end else if (cur_q.mon > 4'd1) begin
        cur_d.mon = lk_mon;
        cur_d.day = cur_mlen;
      end else begin
        cur_d.mon = DEC;
        cur_d.day = 5'd31;
        if (cur_q.year == YEAR_W'(YEAR_MIN)) begin
          cur_d.year = YEAR_W'(YEAR_MAX);
          wrap_d     = 1'b1;
        end else begin
          cur_d.year = cur_q.year - 14'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= date_t'(RESET_DATE);
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      year_wrap <= wrap_d;
      load_err  <= err_d;
    end
  end

  assign date_out = cur_q;
  // Leap depends only on the year, so the current-date lookup serves directly.
  assign leap     = cur_leap;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: stimulus pushes expected results into a
// queue; an independent monitor pops and compares one entry per clock.
module tb_date_counter;

  logic        clk;
  logic        rst;
  logic        day_tick;
  logic        day_back;
  logic        load;
  logic [22:0] load_date;
  logic [22:0] date_out;
  logic        leap;
  logic        year_wrap;
  logic        load_err;

  int checks;
  int errors;

  typedef struct {
    logic [22:0] date;
    logic        wrap;
    logic        err;
    logic        lp;
  } exp_t;

  exp_t exp_q[$];

  date_counter dut (
    .clk       (clk),
    .rst       (rst),
    .day_tick  (day_tick),
    .day_back  (day_back),
    .load      (load),
    .load_date (load_date),
    .date_out  (date_out),
    .leap      (leap),
    .year_wrap (year_wrap),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] d(input int y, input int m, input int dd);
    return {14'(y), 4'(m), 5'(dd)};
  endfunction

  function automatic logic is_leap(input logic [22:0] dt);
    int y;
    y = int'(dt[22:9]);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input logic r, input logic t, input logic b, input logic l,
                      input logic [22:0] ldv, input logic [22:0] ed,
                      input logic ew, input logic ee);
    exp_t e;
    @(negedge clk);
    rst       = r;
    day_tick  = t;
    day_back  = b;
    load      = l;
    load_date = ldv;
    e.date = ed;
    e.wrap = ew;
    e.err  = ee;
    e.lp   = is_leap(ed);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [22:0] ed);
    step(1'b0, 1'b0, 1'b0, 1'b0, 23'd0, ed, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [22:0] v);
    step(1'b0, 1'b0, 1'b0, 1'b1, v, v, 1'b0, 1'b0);
  endtask

  task automatic tick(input logic [22:0] ed, input logic ew);
    step(1'b0, 1'b1, 1'b0, 1'b0, 23'd0, ed, ew, 1'b0);
  endtask

  task automatic back(input logic [22:0] ed, input logic ew);
    step(1'b0, 1'b0, 1'b1, 1'b0, 23'd0, ed, ew, 1'b0);
  endtask

  // Monitor: every cycle after the active edge, check against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (date_out !== e.date) begin
          errors++;
          $display("FAIL date: got %0d-%0d-%0d expected %0d-%0d-%0d", date_out[22:9],
                   date_out[8:5], date_out[4:0], e.date[22:9], e.date[8:5], e.date[4:0]);
        end
        checks++;
        if (year_wrap !== e.wrap) begin
          errors++;
          $display("FAIL year_wrap at %0d-%0d-%0d: got %b expected %b", e.date[22:9],
                   e.date[8:5], e.date[4:0], year_wrap, e.wrap);
        end
        checks++;
        if (load_err !== e.err) begin
          errors++;
          $display("FAIL load_err at %0d-%0d-%0d: got %b expected %b", e.date[22:9],
                   e.date[8:5], e.date[4:0], load_err, e.err);
        end
        checks++;
        if (leap !== e.lp) begin
          errors++;
          $display("FAIL leap at %0d-%0d-%0d: got %b expected %b", e.date[22:9],
                   e.date[8:5], e.date[4:0], leap, e.lp);
        end
      end
    end
  end

  initial begin
    logic [22:0] bad [7];
    int          waited;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    day_tick  = 1'b0;
    day_back  = 1'b0;
    load      = 1'b0;
    load_date = 23'd0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 23'd0, d(2000, 1, 1), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 23'd0, d(2000, 1, 1), 1'b0, 1'b0);

    // 40 ticks from 2000-01-01 reach 2000-02-10, then reset overrides a tick.
    for (int k = 1; k <= 40; k++)
      tick((k <= 30) ? d(2000, 1, k + 1) : d(2000, 2, k - 30), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 23'd0, d(2000, 1, 1), 1'b0, 1'b0);

    // Leap February.
    do_load(d(2024, 2, 28));
    tick(d(2024, 2, 29), 1'b0);
    tick(d(2024, 3, 1), 1'b0);
    do_load(d(2100, 2, 28));
    tick(d(2100, 3, 1), 1'b0);
    do_load(d(2000, 2, 28));
    tick(d(2000, 2, 29), 1'b0);

    // Year wrap both ways; pulse lasts exactly one cycle.
    do_load(d(9999, 12, 31));
    tick(d(1, 1, 1), 1'b1);
    idle(d(1, 1, 1));
    back(d(9999, 12, 31), 1'b1);
    idle(d(9999, 12, 31));

    // Decrement across months and years.
    do_load(d(2023, 3, 1));
    back(d(2023, 2, 28), 1'b0);
    do_load(d(2023, 5, 1));
    back(d(2023, 4, 30), 1'b0);
    do_load(d(2024, 1, 1));
    back(d(2023, 12, 31), 1'b0);
    do_load(d(2024, 3, 1));
    back(d(2024, 2, 29), 1'b0);
    back(d(2024, 2, 28), 1'b0);
    do_load(d(2020, 12, 31));
    tick(d(2021, 1, 1), 1'b0);

    // Illegal loads keep the date and pulse load_err.
    do_load(d(2023, 6, 15));
    bad[0] = d(2023, 2, 29);
    bad[1] = d(2023, 13, 1);
    bad[2] = d(2023, 4, 31);
    bad[3] = d(0, 1, 1);
    bad[4] = d(2023, 1, 0);
    bad[5] = d(10000, 1, 1);
    bad[6] = d(2023, 0, 1);
    foreach (bad[i]) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, bad[i], d(2023, 6, 15), 1'b0, 1'b1);
      idle(d(2023, 6, 15));
    end
    do_load(d(2023, 4, 30));

    // Simultaneous events.
    step(1'b0, 1'b1, 1'b0, 1'b1, d(2020, 1, 1), d(2020, 1, 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 23'd0, d(2020, 1, 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, d(2023, 2, 30), d(2020, 1, 1), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, d(2019, 7, 4), d(2019, 7, 4), 1'b0, 1'b0);
    back(d(2019, 7, 3), 1'b0);
    idle(d(2019, 7, 3));

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
